// File: rtl/mock_bus_pkg.sv
// Shared types, default constants and address helper for the mock bus responder.
package mock_bus_pkg;

    localparam int unsigned DefAddrW     = 16;
    localparam int unsigned DefDataW     = 8;
    localparam int unsigned DefDepthLog2 = 16;
    localparam int unsigned DefMaxWait   = 7;

    localparam logic [DefAddrW-1:0] DefRomEnd  = 16'h7FFF;
    localparam logic [DefDataW-1:0] DefOpenBus = 8'hFF;

    typedef logic [31:0] count_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // True when the address falls inside a 2**depth_log2 word array.
    function automatic logic addr_in_range(logic [31:0] addr, int unsigned depth_log2);
        return (addr >> depth_log2) == 32'd0;
    endfunction

endpackage

// File: rtl/mock_mem_array.sv
// Behavioural word array with two write ports (bus port wins on a same-address
// collision with the backdoor port) and an asynchronous read port. Never reset.
module mock_mem_array
    import mock_bus_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned DEPTH_LOG2 = DefDepthLog2
) (
    input  logic                  clk_i,
    input  logic                  bus_we_i,
    input  logic [DEPTH_LOG2-1:0] bus_addr_i,
    input  logic [DATA_W-1:0]     bus_wdata_i,
    input  logic                  load_we_i,
    input  logic [DEPTH_LOG2-1:0] load_addr_i,
    input  logic [DATA_W-1:0]     load_wdata_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic              load_blocked;

    assign load_blocked = bus_we_i && (bus_addr_i == load_addr_i);

    always_ff @(posedge clk_i) begin
        if (load_we_i && !load_blocked) begin
            mem_q[load_addr_i] <= load_wdata_i;
        end
        if (bus_we_i) begin
            mem_q[bus_addr_i] <= bus_wdata_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mock_bus_responder.sv
// Mock memory responder: valid/ready requests, selectable wait states, ROM and
// open-bus regions, backdoor preload and access counters. MOCK_BUS_TRACE_EN adds a write trace.
module mock_bus_responder
    import mock_bus_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DefAddrW,
    parameter int unsigned       DATA_W     = DefDataW,
    parameter int unsigned       DEPTH_LOG2 = DefDepthLog2,
    parameter int unsigned       MAX_WAIT   = DefMaxWait,
    parameter logic [ADDR_W-1:0] ROM_END    = ADDR_W'(DefRomEnd),
    parameter logic [DATA_W-1:0] OPEN_BUS   = DATA_W'(DefOpenBus),
    localparam int unsigned      WaitW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WaitW-1:0]  wait_sel,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_dropped,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic [31:0]       drop_count,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_addr,
    output logic [DATA_W-1:0] trace_data
);

    state_e            state_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WaitW-1:0]  cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_dropped_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    count_t            rd_count_q;
    count_t            wr_count_q;
    count_t            drop_count_q;

    logic [WaitW-1:0]  wait_eff;
    logic              cur_wr;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_in_range;
    logic              cur_drop;
    logic              rsp_start;
    logic [DATA_W-1:0] mem_rdata;
    logic              bus_we;
    logic              load_we;

    // cur_* is the access that enters RESP this cycle: straight from the request
    // port on a zero-wait accept, otherwise from the latched copy.
    always_comb begin
        wait_eff     = (32'(wait_sel) > MAX_WAIT) ? WaitW'(MAX_WAIT) : wait_sel;
        cur_wr       = (state_q == StIdle) ? req_write : wr_q;
        cur_addr     = (state_q == StIdle) ? req_addr : addr_q;
        cur_in_range = addr_in_range(32'(cur_addr), DEPTH_LOG2);
        cur_drop     = cur_wr && ((cur_addr <= ROM_END) || !cur_in_range);
        rsp_start    = ((state_q == StIdle) && req_valid && (wait_eff == '0)) ||
                       ((state_q == StWait) && (cnt_q == WaitW'(1)));
    end

    assign bus_we  = (state_q == StResp) && wr_q && !rsp_dropped_q && !reset;
    assign load_we = load_en && addr_in_range(32'(load_addr), DEPTH_LOG2);

    mock_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk_i        (clk),
        .bus_we_i     (bus_we),
        .bus_addr_i   (addr_q[DEPTH_LOG2-1:0]),
        .bus_wdata_i  (wdata_q),
        .load_we_i    (load_we),
        .load_addr_i  (load_addr[DEPTH_LOG2-1:0]),
        .load_wdata_i (load_data),
        .rd_addr_i    (cur_addr[DEPTH_LOG2-1:0]),
        .rd_data_o    (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_dropped_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rd_count_q    <= '0;
            wr_count_q    <= '0;
            drop_count_q  <= '0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_dropped_q <= 1'b0;
            rsp_rdata_q   <= '0;

            if (rsp_start) begin
                rsp_valid_q   <= 1'b1;
                rsp_dropped_q <= cur_drop;
                if (!cur_wr) begin
                    rsp_rdata_q <= cur_in_range ? mem_rdata : OPEN_BUS;
                    rd_count_q  <= rd_count_q + 32'd1;
                end else if (cur_drop) begin
                    drop_count_q <= drop_count_q + 32'd1;
                end else begin
                    wr_count_q <= wr_count_q + 32'd1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        cnt_q       <= wait_eff;
                        req_ready_q <= 1'b0;
                        state_q     <= (wait_eff == '0) ? StResp : StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - WaitW'(1);
                    if (cnt_q == WaitW'(1)) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_dropped = rsp_dropped_q;
    assign rd_count    = rd_count_q;
    assign wr_count    = wr_count_q;
    assign drop_count  = drop_count_q;

`ifdef MOCK_BUS_TRACE_EN
    logic [DATA_W-1:0] cur_wdata;
    logic              trace_hit;
    logic              trace_valid_q;
    logic [ADDR_W-1:0] trace_addr_q;
    logic [DATA_W-1:0] trace_data_q;

    assign cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
    assign trace_hit = rsp_start && cur_wr && !cur_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid_q <= 1'b0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
        end else begin
            trace_valid_q <= trace_hit;
            trace_addr_q  <= trace_hit ? cur_addr : '0;
            trace_data_q  <= trace_hit ? cur_wdata : '0;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;
`else
    assign trace_valid = 1'b0;
    assign trace_addr  = '0;
    assign trace_data  = '0;
`endif

endmodule

// File: tb/tb_mock_bus_responder.sv
// Bench for mock_bus_responder: a full-depth and a 4K-deep instance (MAX_WAIT=5) share stimulus
// and are checked against an address-map model kept here. Honours MOCK_BUS_TRACE_EN.
module tb_mock_bus_responder;

    localparam logic [15:0] RomEnd = 16'h7FFF;
`ifdef MOCK_BUS_TRACE_EN
    localparam bit TraceOn = 1'b1;
`else
    localparam bit TraceOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  wait_sel = '0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        load_en = 1'b0;
    logic [15:0] load_addr = '0;
    logic [7:0]  load_data = '0;

    logic        req_ready_b, rsp_valid_b, rsp_dropped_b, tv_b;
    logic [7:0]  rsp_rdata_b, td_b;
    logic [15:0] ta_b;
    logic [31:0] rd_count_b, wr_count_b, drop_count_b;
    logic        req_ready_s, rsp_valid_s, rsp_dropped_s, tv_s;
    logic [7:0]  rsp_rdata_s, td_s;
    logic [15:0] ta_s;
    logic [31:0] rd_count_s, wr_count_s, drop_count_s;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: sparse memories and expected counters for both instances.
    logic [7:0]  mem_b [logic [15:0]];
    logic [7:0]  mem_s [logic [15:0]];
    logic [31:0] exp_rd_b = 0, exp_wr_b = 0, exp_drop_b = 0;
    logic [31:0] exp_rd_s = 0, exp_wr_s = 0, exp_drop_s = 0;

    mock_bus_responder #(.DEPTH_LOG2(16)) dut_b (
        .clk(clk), .reset(reset), .wait_sel(wait_sel), .req_valid(req_valid),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
        .rsp_dropped(rsp_dropped_b), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .rd_count(rd_count_b), .wr_count(wr_count_b),
        .drop_count(drop_count_b), .trace_valid(tv_b), .trace_addr(ta_b), .trace_data(td_b)
    );

    mock_bus_responder #(.DEPTH_LOG2(12), .MAX_WAIT(5)) dut_s (
        .clk(clk), .reset(reset), .wait_sel(wait_sel), .req_valid(req_valid),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready_s), .rsp_valid(rsp_valid_s), .rsp_rdata(rsp_rdata_s),
        .rsp_dropped(rsp_dropped_s), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .rd_count(rd_count_s), .wr_count(wr_count_s),
        .drop_count(drop_count_s), .trace_valid(tv_s), .trace_addr(ta_s), .trace_data(td_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d (required: bench completes)", cyc);
        $fatal(1);
    end

    function automatic bit oob(logic [15:0] a, int dl);
        return (32'(a) >> dl) != 0;
    endfunction

    function automatic int sat_lat(int w, int max_w);
        return 1 + ((w > max_w) ? max_w : w);
    endfunction

    task automatic model_load(input logic [15:0] a, input logic [7:0] d);
        mem_b[a] = d;
        if (!oob(a, 12)) mem_s[a] = d;
    endtask

    task automatic model_reset();
        exp_rd_b = 0; exp_wr_b = 0; exp_drop_b = 0;
        exp_rd_s = 0; exp_wr_s = 0; exp_drop_s = 0;
    endtask

    task automatic model_access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                                output logic [7:0] er_b, output logic [7:0] er_s,
                                output bit ed_b, output bit ed_s);
        ed_b = wr && (a <= RomEnd || oob(a, 16));
        ed_s = wr && (a <= RomEnd || oob(a, 12));
        er_b = wr ? 8'h00 : (oob(a, 16) ? 8'hFF : mem_b[a]);
        er_s = wr ? 8'h00 : (oob(a, 12) ? 8'hFF : mem_s[a]);
        if (!wr) exp_rd_b++; else if (ed_b) exp_drop_b++; else begin exp_wr_b++; mem_b[a] = d; end
        if (!wr) exp_rd_s++; else if (ed_s) exp_drop_s++; else begin exp_wr_s++; mem_s[a] = d; end
    endtask

    task automatic do_load(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
        model_load(a, d);
    endtask

    // Issues one request, scrambles the request bus and wait_sel after acceptance,
    // and reports what each instance returned. Latency -1 means no response seen.
    task automatic bus_access(input bit wr, input logic [15:0] a, input logic [7:0] d,
                              input int w, output int lat_b, output int lat_s,
                              output logic [7:0] rd_b, output logic [7:0] rd_s,
                              output logic dr_b, output logic dr_s, output bit pulse_ok,
                              output logic tv, output logic [15:0] ta, output logic [7:0] td);
        lat_b = -1; lat_s = -1; rd_b = 'x; rd_s = 'x; dr_b = 'x; dr_s = 'x;
        pulse_ok = 1'b0; tv = 'x; ta = 'x; td = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; wait_sel = 3'(w);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = 8'($urandom);
        req_write = 1'($urandom); wait_sel = 3'($urandom);
        for (int i = 1; i <= 20; i++) begin
            if (rsp_valid_b && lat_b < 0) begin
                lat_b = i; rd_b = rsp_rdata_b; dr_b = rsp_dropped_b;
                tv = tv_b; ta = ta_b; td = td_b;
            end
            if (rsp_valid_s && lat_s < 0) begin
                lat_s = i; rd_s = rsp_rdata_s; dr_s = rsp_dropped_s;
            end
            if (lat_b >= 0 && i == lat_b + 1) pulse_ok = !rsp_valid_b && req_ready_b;
            if (lat_b >= 0 && lat_s >= 0 && i > lat_b && i > lat_s) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_cmp++; if ({req_ready_b, rsp_valid_b, rsp_dropped_b, rsp_rdata_b, tv_b} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin n_fail++; $display("FAIL reset_outputs_b got rdy=%b v=%b dr=%b rd=%h tv=%b want 1 0 0 00 0", req_ready_b, rsp_valid_b, rsp_dropped_b, rsp_rdata_b, tv_b); end
        n_cmp++; if ({ta_b, td_b} !== 24'h0) begin n_fail++; $display("FAIL reset_trace_b got %h/%h want 0/0", ta_b, td_b); end
        n_cmp++; if ({rd_count_b, wr_count_b, drop_count_b, rd_count_s, wr_count_s, drop_count_s} !== 192'h0) begin n_fail++; $display("FAIL reset_counters got b=%0d/%0d/%0d s=%0d/%0d/%0d want all 0", rd_count_b, wr_count_b, drop_count_b, rd_count_s, wr_count_s, drop_count_s); end
    endtask

    task automatic test_preload_read();
        int lb, ls; logic [7:0] rb, rs, eb, es; logic db, ds, tv; bit ok, edb, eds;
        logic [15:0] ta; logic [7:0] td;
        do_load(16'hC000, 8'h5A);
        model_access(1'b0, 16'hC000, 8'h00, eb, es, edb, eds);
        bus_access(1'b0, 16'hC000, 8'h00, 0, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
        n_cmp++; if (lb !== 1) begin n_fail++; $display("FAIL preload_lat_b got %0d want 1", lb); end
        n_cmp++; if (rb !== 8'h5A) begin n_fail++; $display("FAIL preload_rdata_b got %h want 5a", rb); end
        n_cmp++; if (rs !== 8'hFF) begin n_fail++; $display("FAIL preload_openbus_s got %h want ff", rs); end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL preload_pulse got %b want 1", ok); end
        n_cmp++; if (rd_count_b !== 32'd1) begin n_fail++; $display("FAIL preload_rd_count got %0d want 1", rd_count_b); end
    endtask

    task automatic test_wait_write_read();
        int lb, ls; logic [7:0] rb, rs, eb, es; logic db, ds, tv; bit ok, edb, eds;
        logic [15:0] ta; logic [7:0] td;
        model_access(1'b1, 16'hC001, 8'h77, eb, es, edb, eds);
        bus_access(1'b1, 16'hC001, 8'h77, 3, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
        n_cmp++; if ({lb, ls} !== {32'd4, 32'd4}) begin n_fail++; $display("FAIL wait3_write_lat got %0d/%0d want 4/4", lb, ls); end
        n_cmp++; if ({rb, db, ds} !== {8'h00, 1'b0, 1'b1}) begin n_fail++; $display("FAIL wait3_write_rsp got rd=%h dr=%b/%b want 00 0/1", rb, db, ds); end
        model_access(1'b0, 16'hC001, 8'h00, eb, es, edb, eds);
        bus_access(1'b0, 16'hC001, 8'h00, 3, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
        n_cmp++; if (lb !== 4) begin n_fail++; $display("FAIL wait3_read_lat got %0d want 4", lb); end
        n_cmp++; if (rb !== 8'h77) begin n_fail++; $display("FAIL wait3_readback got %h want 77", rb); end
        n_cmp++; if (wr_count_b !== 32'd1) begin n_fail++; $display("FAIL wait3_wr_count got %0d want 1", wr_count_b); end
    endtask

    task automatic test_rom_drop();
        int lb, ls; logic [7:0] rb, rs, eb, es; logic db, ds, tv; bit ok, edb, eds;
        logic [15:0] ta; logic [7:0] td;
        do_load(16'h0100, 8'h33);
        model_access(1'b1, 16'h0100, 8'h12, eb, es, edb, eds);
        bus_access(1'b1, 16'h0100, 8'h12, 1, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
        n_cmp++; if ({db, ds} !== 2'b11) begin n_fail++; $display("FAIL rom_dropped got %b%b want 11", db, ds); end
        n_cmp++; if ({drop_count_b, drop_count_s} !== {32'd1, 32'd2}) begin n_fail++; $display("FAIL rom_drop_count got %0d/%0d want 1/2", drop_count_b, drop_count_s); end
        model_access(1'b0, 16'h0100, 8'h00, eb, es, edb, eds);
        bus_access(1'b0, 16'h0100, 8'h00, 0, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
        n_cmp++; if ({rb, rs} !== 16'h3333) begin n_fail++; $display("FAIL rom_readback got %h/%h want 33/33", rb, rs); end
    endtask

    task automatic test_open_bus();
        int lb, ls; logic [7:0] rb, rs, eb, es; logic db, ds, tv; bit ok, edb, eds;
        logic [15:0] ta; logic [7:0] td;
        do_load(16'h2000, 8'h44);
        model_access(1'b0, 16'h2000, 8'h00, eb, es, edb, eds);
        bus_access(1'b0, 16'h2000, 8'h00, 2, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
        n_cmp++; if ({rb, rs} !== 16'h44FF) begin n_fail++; $display("FAIL openbus_read got %h/%h want 44/ff", rb, rs); end
        model_access(1'b1, 16'h2000, 8'h55, eb, es, edb, eds);
        bus_access(1'b1, 16'h2000, 8'h55, 2, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
        n_cmp++; if (ds !== 1'b1) begin n_fail++; $display("FAIL openbus_write_dropped got %b want 1", ds); end
        n_cmp++; if ({rd_count_s, wr_count_s, drop_count_s} !== {exp_rd_s, exp_wr_s, exp_drop_s}) begin n_fail++; $display("FAIL openbus_counters_s got %0d/%0d/%0d want %0d/%0d/%0d", rd_count_s, wr_count_s, drop_count_s, exp_rd_s, exp_wr_s, exp_drop_s); end
    endtask

    task automatic test_collision();
        int lb, ls; logic [7:0] rb, rs, eb, es; logic db, ds, tv; bit ok, edb, eds;
        logic [15:0] ta; logic [7:0] td;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hC010; req_wdata = 8'hAA; wait_sel = 3'd0;
        @(negedge clk);
        req_valid = 1'b0; load_en = 1'b1; load_addr = 16'hC010; load_data = 8'hBB;
        n_cmp++; if (rsp_valid_b !== 1'b1) begin n_fail++; $display("FAIL collide_rsp_valid got %b want 1", rsp_valid_b); end
        @(negedge clk);
        load_en = 1'b0;
        model_load(16'hC010, 8'hBB);
        model_access(1'b1, 16'hC010, 8'hAA, eb, es, edb, eds);
        model_access(1'b0, 16'hC010, 8'h00, eb, es, edb, eds);
        bus_access(1'b0, 16'hC010, 8'h00, 0, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
        n_cmp++; if (rb !== 8'hAA) begin n_fail++; $display("FAIL collide_bus_wins got %h want aa", rb); end
    endtask

    task automatic test_back_to_back();
        int t[3] = '{0, 0, 0};
        int k = 0;
        logic [7:0] eb, es; bit edb, eds;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'hC000; wait_sel = 3'd2;
        for (int i = 0; i < 40 && k < 3; i++) begin
            @(negedge clk);
            if (rsp_valid_b) begin t[k] = cyc; k++; end
        end
        req_valid = 1'b0;
        for (int j = 0; j < 3; j++) model_access(1'b0, 16'hC000, 8'h00, eb, es, edb, eds);
        n_cmp++; if (k !== 3) begin n_fail++; $display("FAIL b2b_pulses got %0d want 3", k); end
        n_cmp++; if ({t[1] - t[0], t[2] - t[1]} !== {32'd4, 32'd4}) begin n_fail++; $display("FAIL b2b_spacing got %0d/%0d want 4/4", t[1] - t[0], t[2] - t[1]); end
        @(negedge clk);
        n_cmp++; if ({rd_count_b, rd_count_s} !== {exp_rd_b, exp_rd_s}) begin n_fail++; $display("FAIL b2b_rd_count got %0d/%0d want %0d/%0d", rd_count_b, rd_count_s, exp_rd_b, exp_rd_s); end
    endtask

    task automatic test_trace();
        int lb, ls; logic [7:0] rb, rs, eb, es; logic db, ds, tv; bit ok, edb, eds;
        logic [15:0] ta; logic [7:0] td;
        model_access(1'b1, 16'hD000, 8'h9C, eb, es, edb, eds);
        bus_access(1'b1, 16'hD000, 8'h9C, 1, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
        n_cmp++; if (tv !== TraceOn) begin n_fail++; $display("FAIL trace_valid got %b want %b", tv, TraceOn); end
        n_cmp++; if ({ta, td} !== (TraceOn ? 24'hD0009C : 24'h0)) begin n_fail++; $display("FAIL trace_payload got %h/%h", ta, td); end
    endtask

    task automatic test_reset_mid();
        int lb, ls; logic [7:0] rb, rs, eb, es; logic db, ds, tv; bit ok, edb, eds;
        logic [15:0] ta; logic [7:0] td;
        int seen = 0;
        do_load(16'hC002, 8'h11);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hC002; req_wdata = 8'h99; wait_sel = 3'd5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_cmp++; if ({req_ready_b, req_ready_s} !== 2'b11) begin n_fail++; $display("FAIL midreset_ready got %b%b want 11", req_ready_b, req_ready_s); end
        n_cmp++; if ({rd_count_b, wr_count_b, drop_count_b, rd_count_s, wr_count_s, drop_count_s} !== 192'h0) begin n_fail++; $display("FAIL midreset_counters got b=%0d/%0d/%0d s=%0d/%0d/%0d want all 0", rd_count_b, wr_count_b, drop_count_b, rd_count_s, wr_count_s, drop_count_s); end
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid_b || rsp_valid_s) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_rsp got %0d pulses want 0", seen); end
        model_access(1'b0, 16'hC002, 8'h00, eb, es, edb, eds);
        bus_access(1'b0, 16'hC002, 8'h00, 0, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
        n_cmp++; if (rb !== 8'h11) begin n_fail++; $display("FAIL midreset_mem got %h want 11", rb); end
    endtask

    task automatic test_random();
        logic [15:0] pool [12];
        logic [15:0] a; logic [7:0] d; bit wr; int w;
        int lb, ls; logic [7:0] rb, rs, eb, es; logic db, ds, tv; bit ok, edb, eds, etv;
        logic [15:0] ta; logic [7:0] td;
        for (int i = 0; i < 12; i++) begin
            case (i / 4)
                0:       pool[i] = 16'($urandom_range(16'h0000, 16'h0FFF));
                1:       pool[i] = 16'($urandom_range(16'h1000, 16'h7FFF));
                default: pool[i] = 16'($urandom_range(16'h8000, 16'hFFFF));
            endcase
            do_load(pool[i], 8'($urandom));
        end
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) do_load(pool[$urandom_range(0, 11)], 8'($urandom));
            a = pool[$urandom_range(0, 11)];
            wr = 1'($urandom);
            d = 8'($urandom);
            w = $urandom_range(0, 7);
            model_access(wr, a, d, eb, es, edb, eds);
            etv = TraceOn && wr && !edb;
            bus_access(wr, a, d, w, lb, ls, rb, rs, db, ds, ok, tv, ta, td);
            n_cmp++; if ({lb, ls} !== {sat_lat(w, 7), sat_lat(w, 5)}) begin n_fail++; $display("FAIL rand%0d_lat w=%0d got %0d/%0d want %0d/%0d", n, w, lb, ls, sat_lat(w, 7), sat_lat(w, 5)); end
            n_cmp++; if ({rb, rs} !== {eb, es}) begin n_fail++; $display("FAIL rand%0d_rdata a=%h wr=%b got %h/%h want %h/%h", n, a, wr, rb, rs, eb, es); end
            n_cmp++; if ({db, ds} !== {edb, eds}) begin n_fail++; $display("FAIL rand%0d_dropped a=%h wr=%b got %b%b want %b%b", n, a, wr, db, ds, edb, eds); end
            n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand%0d_pulse got %b want 1", n, ok); end
            n_cmp++; if ({tv, ta, td} !== {etv, etv ? a : 16'h0, etv ? d : 8'h0}) begin n_fail++; $display("FAIL rand%0d_trace got %b %h %h want %b", n, tv, ta, td, etv); end
        end
        n_cmp++; if ({rd_count_b, wr_count_b, drop_count_b} !== {exp_rd_b, exp_wr_b, exp_drop_b}) begin n_fail++; $display("FAIL rand_counters_b got %0d/%0d/%0d want %0d/%0d/%0d", rd_count_b, wr_count_b, drop_count_b, exp_rd_b, exp_wr_b, exp_drop_b); end
        n_cmp++; if ({rd_count_s, wr_count_s, drop_count_s} !== {exp_rd_s, exp_wr_s, exp_drop_s}) begin n_fail++; $display("FAIL rand_counters_s got %0d/%0d/%0d want %0d/%0d/%0d", rd_count_s, wr_count_s, drop_count_s, exp_rd_s, exp_wr_s, exp_drop_s); end
    endtask

    initial begin
        test_reset();
        test_preload_read();
        test_wait_write_read();
        test_rom_drop();
        test_open_bus();
        test_collision();
        test_back_to_back();
        test_trace();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mock_bus_responder.md
Name: mock_bus_responder

Overview:
Parametrised successor to the fixed mock memory used by CPU-level test harnesses. Sits between the CPU bus master and a behavioural memory array. Adds:
- a valid/ready request handshake
- a runtime-selectable wait-state count
- a write-protected ROM region
- an out-of-range open-bus response
- a backdoor preload port
- access counters for bench checking

Parameters:
ADDR_W, 16, address width in bits
DATA_W, 8, data width in bits
DEPTH_LOG2, 16, memory holds 2**DEPTH_LOG2 words; DEPTH_LOG2 <= ADDR_W
MAX_WAIT, 7, largest legal wait-state count
ROM_END, 16'h7FFF, addresses 0..ROM_END are read-only from the bus
OPEN_BUS, 8'hFF, read data returned for addresses >= 2**DEPTH_LOG2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wait_sel  in  $clog2(MAX_WAIT+1)  wait states per access; values above MAX_WAIT saturate to MAX_WAIT
req_valid  in  1  master presents a request
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
req_ready  out  1  responder can accept a request
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes
rsp_dropped  out  1  with rsp_valid: write was discarded (ROM or out of range)
load_en  in  1  backdoor write strobe
load_addr  in  ADDR_W  backdoor address
load_data  in  DATA_W  backdoor data
rd_count  out  32  completed reads
wr_count  out  32  committed writes
drop_count  out  32  dropped writes
trace_valid  out  1  trace pulse (optional feature)
trace_addr  out  ADDR_W  trace address
trace_data  out  DATA_W  trace data

Behaviour:
- One clock; reset is synchronous and active-high, using the codebase names clk and reset.
- Reset values:
  - FSM goes to IDLE; req_ready=1.
  - rsp_valid, rsp_rdata, rsp_dropped, all counters and all trace outputs are 0.
  - Memory contents are NOT cleared, so preloads survive reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/addr/wdata and wait count (saturated wait_sel).
  - Wait count 0 -> RESP; otherwise -> WAIT.
- WAIT:
  - req_ready=0; down-counter decrements each cycle.
  - Go to RESP on the cycle the counter reaches 1.
- RESP:
  - req_ready=0; rsp_valid=1 for exactly one cycle; then back to IDLE.
  - Latency: request accepted at cycle N gives rsp_valid at cycle N+1+W.
  - Back-to-back throughput is one access per 2+W cycles.
- Reads: return memory data sampled in RESP. If addr >= 2**DEPTH_LOG2, return OPEN_BUS. Increment rd_count.
- Writes: commit on the RESP cycle.
  - If addr <= ROM_END or addr >= 2**DEPTH_LOG2: no memory update, rsp_dropped=1, drop_count++.
  - Otherwise: memory updated, wr_count++.
- req_wdata/req_addr changes after acceptance are ignored.
- Backdoor load:
  - Writes memory in the cycle load_en=1, in any state, ignoring ROM protection.
  - Out-of-range addresses are ignored.
  - Same-cycle collision with a bus write commit to the same address: the bus write wins.
  - Loads never touch counters.
- Counters wrap modulo 2**32.
- Reset mid-access (WAIT or RESP): access aborted, no memory update, no rsp_valid.
- wait_sel changes mid-access do not affect the in-flight access.

Optional Feature:
Macro MOCK_BUS_TRACE_EN.
- Defined: trace_valid pulses on every committed, non-dropped bus write, in the same cycle as rsp_valid. trace_addr/trace_data carry the written address and data.
- Undefined: trace_* outputs are tied to 0 and no trace logic is built.

Decomposition:
- Package mock_bus_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - default parameter constants (ADDR_W/DATA_W/ROM_END/OPEN_BUS)
  - 32-bit counter typedef
- Sub-module mock_mem_array: dual-write-port array (bus port priority over backdoor port) with an asynchronous read port, parametrised by DATA_W and DEPTH_LOG2.

Test Plan:
- Preload 0xC000=0x5A via the load port, wait_sel=0, read 0xC000: rsp_valid one cycle after accept, rdata=0x5A, rd_count=1.
- wait_sel=3, write 0xC001=0x77 then read it back: rsp_valid 4 cycles after each accept; rdata=0x77; wr_count=1.
- Write 0x0100=0x12 (ROM): rsp_dropped=1, drop_count=1. A subsequent read of 0x0100 returns the preloaded value unchanged.
- DEPTH_LOG2=12, read 0x2000: rdata=0xFF. Write 0x2000: dropped, drop_count increments.
- wait_sel=5, assert reset during WAIT after a write to 0xC002: no rsp_valid, memory at 0xC002 unchanged, all counters 0, req_ready=1 the next cycle.
- MOCK_BUS_TRACE_EN defined, write 0xD000=0x9C: trace_valid, trace_addr=0xD000 and trace_data=0x9C coincide with rsp_valid. Without the macro, trace_valid stays 0.
